// File: rtl/inputbus_repeat.sv
// inputbus_repeat: push-button front end for the game core.
// Synchronises and debounces raw buttons, turns presses (and DAS/ARR
// auto-repeat on selected buttons) into move codes, queues them in a
// small first-word-fall-through FIFO and hands them out over valid/ready.
module inputbus_repeat #(
  parameter int unsigned        NUM_BTN      = 5,
  parameter int unsigned        DEBOUNCE_CYC = 4,
  parameter int unsigned        DAS_CYC      = 16,
  parameter int unsigned        ARR_CYC      = 4,
  parameter logic [NUM_BTN-1:0] REPEAT_MASK  = 5'b10011,
  parameter int unsigned        FIFO_DEPTH   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] btn_raw_i,
  output logic [2:0]         move_o,
  output logic               move_valid_o,
  input  logic               move_ready_i,
  output logic [NUM_BTN-1:0] btn_held_o,
  output logic               drop_pulse_o
);

  localparam int unsigned DB_W    = $clog2(DEBOUNCE_CYC + 1);
  localparam int unsigned REP_MAX = (DAS_CYC > ARR_CYC) ? DAS_CYC : ARR_CYC;
  localparam int unsigned REP_W   = $clog2(REP_MAX + 1);
  localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W   = PTR_W + 1;
  localparam logic [2:0]  MOVE_NONE = 3'b111;

  logic [NUM_BTN-1:0]            sync1_q, sync2_q;
  logic [NUM_BTN-1:0]            stable_q, stable_d;
  logic [NUM_BTN-1:0][DB_W-1:0]  db_cnt_q, db_cnt_d;
  logic [NUM_BTN-1:0]            rise_q, rise_d;
  logic [NUM_BTN-1:0][REP_W-1:0] rep_cnt_q, rep_cnt_d;
  logic [NUM_BTN-1:0]            arr_q, arr_d;
  logic [NUM_BTN-1:0]            event_c;
  logic [NUM_BTN-1:0]            pend_q, pend_d;
  logic [NUM_BTN-1:0]            grant_c;
  logic                          push_c, pop_c, can_push_c;
  logic [2:0]                    wdata_c;
  logic                          drop_q, drop_d;
  logic [FIFO_DEPTH-1:0][2:0]    mem_q, mem_d;
  logic [PTR_W-1:0]              wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]              rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]              count_q, count_d;
  logic [2:0]                    move_q, move_d;
  logic                          valid_q, valid_d;

  // Debounce: accept a new level after DEBOUNCE_CYC consecutive disagreeing cycles.
  always_comb begin
    stable_d = stable_q;
    db_cnt_d = db_cnt_q;
    rise_d   = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      if (sync2_q[i] == stable_q[i]) begin
        db_cnt_d[i] = '0;
      end else if (db_cnt_q[i] == DB_W'(DEBOUNCE_CYC - 1)) begin
        stable_d[i] = sync2_q[i];
        db_cnt_d[i] = '0;
        rise_d[i]   = sync2_q[i];
      end else begin
        db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
      end
    end
  end

  // Events: one per press, plus DAS then ARR-spaced repeats on masked buttons.
  always_comb begin
    rep_cnt_d = rep_cnt_q;
    arr_d     = arr_q;
    event_c   = rise_q;
    for (int i = 0; i < NUM_BTN; i++) begin
      if (REPEAT_MASK[i]) begin
        if (!stable_q[i]) begin
          rep_cnt_d[i] = '0;
          arr_d[i]     = 1'b0;
        end else if (rise_q[i]) begin
          rep_cnt_d[i] = REP_W'(1);
          arr_d[i]     = 1'b0;
        end else if (rep_cnt_q[i] == (arr_q[i] ? REP_W'(ARR_CYC) : REP_W'(DAS_CYC))) begin
          event_c[i]   = 1'b1;
          rep_cnt_d[i] = REP_W'(1);
          arr_d[i]     = 1'b1;
        end else if (rep_cnt_q[i] != REP_W'(REP_MAX)) begin
          rep_cnt_d[i] = rep_cnt_q[i] + REP_W'(1);
        end
      end
    end
  end

  // Pending bits, lowest-index arbiter and FWFT queue with registered head.
  always_comb begin
    pop_c      = valid_q && move_ready_i;
    can_push_c = (count_q != CNT_W'(FIFO_DEPTH)) || pop_c;
    grant_c    = '0;
    push_c     = 1'b0;
    wdata_c    = MOVE_NONE;
    for (int i = 0; i < NUM_BTN; i++) begin
      if (!push_c && pend_q[i] && can_push_c) begin
        grant_c[i] = 1'b1;
        push_c     = 1'b1;
        wdata_c    = 3'(i);
      end
    end
    pend_d = (pend_q & ~grant_c) | event_c;
    drop_d = |(event_c & pend_q & ~grant_c);

    mem_d = mem_q;
    if (push_c) mem_d[wr_ptr_q] = wdata_c;
    wr_ptr_d = push_c ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop_c  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push_c && !pop_c)      count_d = count_q + CNT_W'(1);
    else if (!push_c && pop_c) count_d = count_q - CNT_W'(1);

    valid_d = (count_d != '0);
    if (count_d == '0)
      move_d = MOVE_NONE;
    else if (push_c && ((count_q == '0) || ((count_q == CNT_W'(1)) && pop_c)))
      move_d = wdata_c;
    else
      move_d = mem_q[rd_ptr_d];
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      stable_q  <= '0;
      db_cnt_q  <= '0;
      rise_q    <= '0;
      rep_cnt_q <= '0;
      arr_q     <= '0;
      pend_q    <= '0;
      drop_q    <= 1'b0;
      mem_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      move_q    <= MOVE_NONE;
      valid_q   <= 1'b0;
    end else begin
      sync1_q   <= btn_raw_i;
      sync2_q   <= sync1_q;
      stable_q  <= stable_d;
      db_cnt_q  <= db_cnt_d;
      rise_q    <= rise_d;
      rep_cnt_q <= rep_cnt_d;
      arr_q     <= arr_d;
      pend_q    <= pend_d;
      drop_q    <= drop_d;
      mem_q     <= mem_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      move_q    <= move_d;
      valid_q   <= valid_d;
    end
  end

  assign move_o       = move_q;
  assign move_valid_o = valid_q;
  assign btn_held_o   = stable_q;
  assign drop_pulse_o = drop_q;

endmodule

// File: tb/tb_inputbus_repeat.sv
// Bench for inputbus_repeat: vector table, hand sequences for queue/drop/reset
// corners, and random button activity checked every cycle against a model.
module tb_inputbus_repeat;

  localparam int NB    = 5;
  localparam int DB    = 4;
  localparam int DAS   = 16;
  localparam int ARR   = 4;
  localparam int DEPTH = 4;
  localparam logic [NB-1:0] RMASK = 5'b10011;

  logic          clk = 1'b0;
  logic          rst;
  logic [NB-1:0] btn_raw;
  logic [2:0]    move;
  logic          move_valid;
  logic          move_ready;
  logic [NB-1:0] btn_held;
  logic          drop_pulse;

  inputbus_repeat #(
    .NUM_BTN(NB), .DEBOUNCE_CYC(DB), .DAS_CYC(DAS), .ARR_CYC(ARR),
    .REPEAT_MASK(RMASK), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .btn_raw_i(btn_raw), .move_o(move),
    .move_valid_o(move_valid), .move_ready_i(move_ready),
    .btn_held_o(btn_held), .drop_pulse_o(drop_pulse)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int drops;

  // Reference model: sync delay line, window-based debounce, press timestamps
  // for repeat timing, pending bits and a queue for the FIFO.
  int            m_cyc = 0;
  logic [NB-1:0] m_s1, m_s2, m_stable, m_pend;
  logic [NB-1:0] m_hist [DB];
  int            m_press [NB];
  logic          m_drop;
  int            m_q[$];

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (model cycle %0d)", name, got, exp, m_cyc);
    end
  endtask

  task automatic model_step(input logic [NB-1:0] raw, input logic rdy, input logic r);
    logic [NB-1:0] ev;
    int  g, d;
    bit  pop, can_push, all_diff;
    if (r) begin
      m_s1 = '0; m_s2 = '0; m_stable = '0; m_pend = '0; m_drop = 1'b0;
      for (int k = 0; k < DB; k++) m_hist[k] = '0;
      for (int i = 0; i < NB; i++) m_press[i] = -1;
      m_q.delete();
    end else begin
      ev = '0;
      for (int i = 0; i < NB; i++) begin
        if (m_press[i] >= 0) begin
          d = m_cyc - m_press[i];
          if (d == 0 || (RMASK[i] && d >= DAS && ((d - DAS) % ARR) == 0)) ev[i] = 1'b1;
        end
      end
      pop      = (m_q.size() > 0) && rdy;
      can_push = (m_q.size() < DEPTH) || pop;
      g = -1;
      if (can_push)
        for (int i = NB - 1; i >= 0; i--) if (m_pend[i]) g = i;
      m_drop = 1'b0;
      for (int i = 0; i < NB; i++) if (ev[i] && m_pend[i] && g != i) m_drop = 1'b1;
      if (g >= 0) m_pend[g] = 1'b0;
      m_pend = m_pend | ev;
      if (pop) void'(m_q.pop_front());
      if (g >= 0) m_q.push_back(g);
      for (int k = DB - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
      m_hist[0] = m_s2;
      for (int i = 0; i < NB; i++) begin
        all_diff = 1'b1;
        for (int k = 0; k < DB; k++) if (m_hist[k][i] == m_stable[i]) all_diff = 1'b0;
        if (all_diff) begin
          m_stable[i] = ~m_stable[i];
          m_press[i]  = m_stable[i] ? m_cyc + 1 : -1;
        end
      end
      m_s2 = m_s1;
      m_s1 = raw;
    end
    m_cyc++;
  endtask

  // One clock: advance the model with the sampled inputs, then compare.
  task automatic tick();
    @(posedge clk);
    model_step(btn_raw, move_ready, rst);
    #1;
    check("model_valid", int'(move_valid), int'(m_q.size() > 0));
    check("model_move", int'(move), (m_q.size() > 0) ? m_q[0] : 7);
    check("model_held", int'(btn_held), int'(m_stable));
    check("model_drop", int'(drop_pulse), int'(m_drop));
  endtask

  task automatic rst_dut();
    rst = 1'b1; btn_raw = '0;
    repeat (3) tick();
    rst = 1'b0;
  endtask

  task automatic press(input int b, input int hi, input int lo);
    btn_raw[b] = 1'b1;
    repeat (hi) begin tick(); drops += int'(drop_pulse); end
    btn_raw[b] = 1'b0;
    repeat (lo) begin tick(); drops += int'(drop_pulse); end
  endtask

  typedef struct {
    int btn;
    int hold;
    int exp_moves;
    int exp_first;
    int exp_held;
  } vec_t;

  vec_t vecs[7];

  task automatic run_vec(input vec_t v);
    int moves, first, held_seen, bad_code;
    moves = 0; first = 0; held_seen = 0; bad_code = 0;
    move_ready = 1'b1;
    btn_raw = '0;
    btn_raw[v.btn] = 1'b1;
    for (int k = 1; k <= 70; k++) begin
      tick();
      if (k == v.hold) btn_raw = '0;
      if (move_valid) begin
        moves++;
        if (first == 0) first = k;
        if (int'(move) != v.btn) bad_code++;
      end
      if (btn_held[v.btn]) held_seen = 1;
    end
    check("vec_moves", moves, v.exp_moves);
    check("vec_first_valid_edge", first, v.exp_first);
    check("vec_bad_codes", bad_code, 0);
    check("vec_held_seen", held_seen, v.exp_held);
  endtask

  initial begin
    int got[$];
    int first;
    vecs[0] = '{0, 20, 2, 8, 1};
    vecs[1] = '{2,  3, 0, 0, 0};
    vecs[2] = '{2,  4, 1, 8, 1};
    vecs[3] = '{1, 40, 7, 8, 1};
    vecs[4] = '{3, 40, 1, 8, 1};
    vecs[5] = '{4, 16, 1, 8, 1};
    vecs[6] = '{4, 17, 2, 8, 1};

    for (int i = 0; i < NB; i++) m_press[i] = -1;
    move_ready = 1'b0;
    rst_dut();
    check("reset_valid", int'(move_valid), 0);
    check("reset_move", int'(move), 7);
    check("reset_held", int'(btn_held), 0);
    check("reset_drop", int'(drop_pulse), 0);

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Simultaneous press of buttons 3 and 0: drained lowest index first.
    move_ready = 1'b1;
    btn_raw = 5'b01001;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k == 10) btn_raw = '0;
      if (k == 8) begin
        check("simul_valid_e8", int'(move_valid), 1);
        check("simul_move_e8", int'(move), 0);
      end
      if (k == 9) begin
        check("simul_valid_e9", int'(move_valid), 1);
        check("simul_move_e9", int'(move), 3);
      end
      if (k == 10) check("simul_valid_e10", int'(move_valid), 0);
    end
    repeat (20) tick();

    // Five sequential presses with consumer stalled: 4 queued, 1 pending.
    rst_dut();
    move_ready = 1'b0;
    drops = 0;
    for (int b = 0; b < NB; b++) press(b, 6, 8);
    repeat (10) begin tick(); drops += int'(drop_pulse); end
    check("stall_valid", int'(move_valid), 1);
    check("stall_head", int'(move), 0);
    move_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      if (move_valid) got.push_back(int'(move));
      tick();
      drops += int'(drop_pulse);
    end
    check("stall_delivered", got.size(), 5);
    for (int i = 0; i < 5; i++) if (i < got.size()) check("stall_order", got[i], i);
    check("stall_drops", drops, 0);

    // Re-press of a pending button with full queue, then reset mid-hold.
    rst_dut();
    move_ready = 1'b0;
    drops = 0;
    for (int b = 0; b < NB; b++) press(b, 6, 8);
    check("fill_drops", drops, 0);
    drops = 0;
    press(4, 6, 8);
    check("repress_drops", drops, 1);
    btn_raw[1] = 1'b1;
    repeat (10) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_valid", int'(move_valid), 0);
    check("midrst_held", int'(btn_held), 0);
    move_ready = 1'b1;
    first = 0;
    for (int k = 1; k <= 40 && first == 0; k++) begin
      tick();
      if (move_valid) begin
        first = k;
        check("rearm_move", int'(move), 1);
      end
    end
    check("rearm_first_edge", first, 8);
    btn_raw = '0;
    repeat (20) tick();

    // Random button activity, ready and occasional reset against the model.
    rst_dut();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NB; i++)
        if ($urandom_range(0, 11) == 0) btn_raw[i] = ~btn_raw[i];
      move_ready = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 599) == 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
